serial_adder: RTL

Bit-serial adder that computes A + B + CIN over WIDTH clock cycles, one bit per cycle, LSB first. It reuses the team's existing `full_adder` cell for every bit position, with a registered carry feeding back into the cell each cycle. It is the sequential, area-minimal counterpart of the ripple-carry adder. It sits between an operand source that issues START pulses and a consumer that samples SUM/COUT on DONE.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/full_adder.sv | 21 ++
 rtl/serial_adder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   state_t      - FSM state encoding (IDLE/SHIFT/FIN; code 2'd3 is unused and
//                  recovers to IDLE inside the FSM)
//   count_width  - width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   // One extra bit beyond clog2 so the counter can never wrap, even at WIDTH=32.
   function automatic int count_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit combinational full adder cell.
// Ports:
//   a, b  in  1  operand bits
//   ci    in  1  carry in
//   s     out 1  sum bit
//   co    out 1  carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder computing {COUT,SUM} = A + B + CIN, one bit per clock,
// LSB first, using a single full_adder cell with a registered carry loop.
// A START accepted in IDLE leads to WIDTH SHIFT cycles (BUSY high), then one
// FIN cycle (DONE high). SUM/COUT update on the edge that ends the last SHIFT
// cycle and hold until the next completion.
// Ports:
//   CLK    in  1      clock, rising edge
//   RST    in  1      asynchronous active-high reset
//   START  in  1      request an addition (accepted only in IDLE)
//   A, B   in  WIDTH  operands, sampled on the accepting edge
//   CIN    in  1      carry in, sampled on the accepting edge
//   BUSY   out 1      high during the WIDTH shift cycles
//   DONE   out 1      one-cycle pulse, SUM/COUT valid from this cycle
//   SUM    out WIDTH  result register
//   COUT   out 1      final carry out
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int            CW   = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   full_adder u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Result shift register view including the bit being produced this cycle.
   // Written as shift-then-overwrite so WIDTH=1 needs no special case.
   always_comb begin
      s_next            = s_sr >> 1;
      s_next[WIDTH-1]   = fa_s;
   end

   assign last_bit = (count == LAST);

   // BUSY/DONE are registered alongside the state so they decode glitch-free
   // and never depend combinationally on inputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
         SUM   <= '0;
         COUT  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  carry <= CIN;
                  count <= '0;
                  state <= SHIFT;
                  BUSY  <= 1'b1;
               end
            end

            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= s_next;
               carry <= fa_co;
               count <= count + 1'b1;
               if (last_bit) begin
                  SUM   <= s_next;
                  COUT  <= fa_co;
                  state <= FIN;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end

            FIN: begin
               DONE  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               // Unused encoding: fall back to a clean idle.
               state <= IDLE;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
            end
         endcase
      end
   end

endmodule
